// File: rtl/tach_rpm_meter_if.sv
// Result bundle of the tach RPM meter: raw pulse in, measured RPM and status out.
// The meter side uses master; a consumer or bench driving the pulse uses slave.
interface tach_rpm_meter_if;
    logic        pulse_in;
    logic [15:0] rpm;
    logic        rpm_valid;
    logic        rpm_sat;
    logic        stalled;
    logic        busy;

    modport master (
        input  pulse_in,
        output rpm, rpm_valid, rpm_sat, stalled, busy
    );

    modport slave (
        output pulse_in,
        input  rpm, rpm_valid, rpm_sat, stalled, busy
    );
endinterface

// File: rtl/tach_rpm_meter.sv
// Tach period meter: synchronises the pulse, times accepted rising edges and
// converts the period to a saturated 16-bit RPM with a restoring divider.
//
// state | meaning
// IDLE  | waiting for an accepted period strobe
// DIV   | 32 restoring iterations, one quotient bit per cycle
// DONE  | publish saturated quotient, pulse rpm_valid
module tach_rpm_meter #(
    parameter int unsigned CLK_RATE       = 50000000,
    parameter int unsigned PPR            = 1,
    parameter int unsigned MIN_PERIOD     = 1000,
    parameter int unsigned TIMEOUT_CYCLES = 100000000
) (
    input  logic              clk,
    input  logic              rst_n,
    tach_rpm_meter_if.master  bus
);
    localparam logic [31:0] NUM     = 32'((64'd60 * 64'(CLK_RATE)) / 64'(PPR));
    localparam logic [31:0] MIN_CNT = 32'(MIN_PERIOD);
    localparam logic [31:0] TMO_CNT = 32'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

    logic        sync1, sync2, prev;
    logic        rise, accept, timeout_hit;
    logic        armed, accept_q;
    logic [31:0] cnt, period;

    state_t      state;
    logic [4:0]  iter;
    logic [31:0] quo, divisor, rem;
    logic [32:0] rem_shift, rem_diff;
    logic [15:0] rpm_q;
    logic        rpm_valid_q, rpm_sat_q, stalled_q, busy_q;

    assign rise        = sync2 & ~prev;
    assign accept      = rise & armed & (cnt >= MIN_CNT);
    // An edge landing on the timeout cycle is a valid measurement and wins.
    assign timeout_hit = armed & ~rise & (cnt == TMO_CNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            prev     <= 1'b0;
            cnt      <= '0;
            period   <= '0;
            armed    <= 1'b0;
            accept_q <= 1'b0;
        end else begin
            sync1    <= bus.pulse_in;
            sync2    <= sync1;
            prev     <= sync2;
            accept_q <= accept;
            if (accept) begin
                period <= cnt;
            end
            if (rise && !armed) begin
                cnt   <= 32'd1;
                armed <= 1'b1;
            end else if (accept) begin
                cnt <= 32'd1;
            end else begin
                if (timeout_hit) begin
                    armed <= 1'b0;
                end
                if (cnt != TMO_CNT) begin
                    cnt <= cnt + 32'd1;
                end
            end
        end
    end

    always_comb begin
        rem_shift = {rem, quo[31]};
        rem_diff  = rem_shift - {1'b0, divisor};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            iter        <= '0;
            quo         <= '0;
            divisor     <= '0;
            rem         <= '0;
            rpm_q       <= '0;
            rpm_valid_q <= 1'b0;
            rpm_sat_q   <= 1'b0;
            stalled_q   <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            rpm_valid_q <= 1'b0;
            if (timeout_hit) begin
                rpm_q       <= '0;
                rpm_sat_q   <= 1'b0;
                rpm_valid_q <= 1'b1;
                stalled_q   <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (accept_q) begin
                        quo     <= NUM;
                        divisor <= period;
                        rem     <= '0;
                        iter    <= 5'd31;
                        busy_q  <= 1'b1;
                        state   <= DIV;
                    end
                end
                DIV: begin
                    // Borrow out of the trial subtraction means restore.
                    if (rem_diff[32]) begin
                        rem <= rem_shift[31:0];
                        quo <= {quo[30:0], 1'b0};
                    end else begin
                        rem <= rem_diff[31:0];
                        quo <= {quo[30:0], 1'b1};
                    end
                    if (iter == 5'd0) begin
                        state <= DONE;
                    end else begin
                        iter <= iter - 5'd1;
                    end
                end
                DONE: begin
                    if (|quo[31:16]) begin
                        rpm_q     <= 16'hFFFF;
                        rpm_sat_q <= 1'b1;
                    end else begin
                        rpm_q     <= quo[15:0];
                        rpm_sat_q <= 1'b0;
                    end
                    rpm_valid_q <= 1'b1;
                    stalled_q   <= 1'b0;
                    busy_q      <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.rpm       = rpm_q;
    assign bus.rpm_valid = rpm_valid_q;
    assign bus.rpm_sat   = rpm_sat_q;
    assign bus.stalled   = stalled_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_tach_rpm_meter.sv
// Bench for tach_rpm_meter: three parameterisations share one pulse stream and
// are compared each cycle against an event-time model of the measurement rules.
module tb_tach_rpm_meter;
    localparam int MINP = 40;
    localparam int TMO  = 5000;
    localparam int LAT  = 34;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic pulse = 1'b0;

    always #5 clk = ~clk;

    tach_rpm_meter_if bus0();
    tach_rpm_meter_if bus1();
    tach_rpm_meter_if bus2();

    assign bus0.pulse_in = pulse;
    assign bus1.pulse_in = pulse;
    assign bus2.pulse_in = pulse;

    tach_rpm_meter #(.CLK_RATE(1000), .PPR(1), .MIN_PERIOD(40), .TIMEOUT_CYCLES(5000))
        dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.master));
    tach_rpm_meter #(.CLK_RATE(1000), .PPR(4), .MIN_PERIOD(40), .TIMEOUT_CYCLES(5000))
        dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.master));
    tach_rpm_meter #(.CLK_RATE(50000000), .PPR(1), .MIN_PERIOD(40), .TIMEOUT_CYCLES(5000))
        dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2.master));

    logic [15:0] rpm_o   [3];
    logic        valid_o [3];
    logic        sat_o   [3];
    logic        stall_o [3];
    logic        busy_o  [3];

    assign rpm_o[0] = bus0.rpm;  assign valid_o[0] = bus0.rpm_valid; assign sat_o[0] = bus0.rpm_sat;
    assign rpm_o[1] = bus1.rpm;  assign valid_o[1] = bus1.rpm_valid; assign sat_o[1] = bus1.rpm_sat;
    assign rpm_o[2] = bus2.rpm;  assign valid_o[2] = bus2.rpm_valid; assign sat_o[2] = bus2.rpm_sat;
    assign stall_o[0] = bus0.stalled; assign busy_o[0] = bus0.busy;
    assign stall_o[1] = bus1.stalled; assign busy_o[1] = bus1.busy;
    assign stall_o[2] = bus2.stalled; assign busy_o[2] = bus2.busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    function automatic longint num_of(input int k);
        case (k)
            0:       return 64'd60 * 1000 / 1;
            1:       return 64'd60 * 1000 / 4;
            default: return 64'd60 * 50000000 / 1;
        endcase
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            if (errors <= 30)
                $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: edges are event times; a period is the gap between accepted edges.
    int          armed = 0, arm_t = 0, m_stalled = 1, due = -1;
    int          busy_lo = 1, busy_hi = 0, prev_p = 0, per = 0, m_valid = 0;
    int          edge_q[$];
    logic [15:0] m_rpm [3];
    logic        m_sat [3];
    logic [15:0] d_rpm [3];
    logic        d_sat [3];
    longint      q;

    always @(posedge clk) begin
        cyc++;
        m_valid = 0;
        if (!rst_n) begin
            armed = 0; m_stalled = 1; due = -1; busy_lo = 1; busy_hi = 0; prev_p = 0;
            edge_q.delete();
            for (int k = 0; k < 3; k++) begin m_rpm[k] = '0; m_sat[k] = 1'b0; end
        end else begin
            if (edge_q.size() > 0 && edge_q[0] == cyc) begin
                void'(edge_q.pop_front());
                if (armed == 0) begin
                    armed = 1; arm_t = cyc;
                end else if (cyc - arm_t >= MINP) begin
                    per = cyc - arm_t; arm_t = cyc;
                    due = cyc + LAT; busy_lo = cyc + 1; busy_hi = cyc + LAT - 1;
                    for (int k = 0; k < 3; k++) begin
                        q = num_of(k) / per;
                        d_rpm[k] = (q > 65535) ? 16'hFFFF : 16'(q);
                        d_sat[k] = (q > 65535);
                    end
                end
            end else if (armed != 0 && cyc - arm_t == TMO) begin
                armed = 0; m_stalled = 1; m_valid = 1;
                for (int k = 0; k < 3; k++) begin m_rpm[k] = '0; m_sat[k] = 1'b0; end
            end
            if (cyc == due) begin
                m_valid = 1; m_stalled = 0; due = -1;
                for (int k = 0; k < 3; k++) begin m_rpm[k] = d_rpm[k]; m_sat[k] = d_sat[k]; end
            end
            // A rise sampled at this edge reaches the edge detector two edges later.
            if (pulse && prev_p == 0) edge_q.push_back(cyc + 2);
            prev_p = pulse ? 1 : 0;
        end
        #2;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rpm%0d", k), rpm_o[k], m_rpm[k]);
            chk($sformatf("rpm_valid%0d", k), valid_o[k], m_valid);
            chk($sformatf("rpm_sat%0d", k), sat_o[k], m_sat[k]);
            chk($sformatf("stalled%0d", k), stall_o[k], m_stalled);
            chk($sformatf("busy%0d", k), busy_o[k], (cyc >= busy_lo && cyc <= busy_hi) ? 1 : 0);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rise_after(input int gap, input int width);
        pulse = 1'b1; tick(width);
        pulse = 1'b0; tick(gap - width);
    endtask

    task automatic glitch_period(input int gap);
        pulse = 1'b1; tick(3);
        pulse = 1'b0; tick(7);
        pulse = 1'b1; tick(1);
        pulse = 1'b0; tick(gap - 11);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r, gap, wmax;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        tick(1);
        chk("reset_rpm", rpm_o[0], 0);
        chk("reset_stalled", stall_o[0], 1);
        chk("reset_busy", busy_o[0], 0);

        repeat (6) rise_after(100, 5);
        chk("p100_rpm", rpm_o[0], 600);
        chk("p100_stalled", stall_o[0], 0);
        chk("p100_ppr4_rpm", rpm_o[1], 150);
        chk("p100_fast_sat", sat_o[2], 1);

        rise_after(1000, 5);
        rise_after(250, 7);
        chk("p1000_rpm", rpm_o[0], 60);
        rise_after(100, 5);
        chk("p250_rpm", rpm_o[0], 240);

        repeat (3) glitch_period(100);
        rise_after(100, 5);
        chk("glitch_rpm", rpm_o[0], 600);

        repeat (4) rise_after(50, 5);
        chk("ppr4_rpm", rpm_o[1], 300);
        chk("ppr4_sat", sat_o[1], 0);
        chk("fast_rpm", rpm_o[2], 16'hFFFF);
        chk("fast_sat", sat_o[2], 1);

        repeat (2) rise_after(100, 5);
        chk("prestall_rpm", rpm_o[0], 600);
        tick(4950);
        chk("stall_rpm", rpm_o[0], 0);
        chk("stall_flag", stall_o[0], 1);
        rise_after(100, 5);
        chk("rearm_stalled", stall_o[0], 1);
        rise_after(100, 5);
        chk("rearm_rpm", rpm_o[0], 600);
        chk("rearm_stalled_clr", stall_o[0], 0);

        for (int i = 0; i < 30; i++) begin
            r = $urandom_range(0, 9);
            if (r == 0)      gap = 5200;
            else if (r == 1) gap = $urandom_range(2, 39);
            else             gap = $urandom_range(60, 1000);
            if (r == 2) begin
                glitch_period(gap);
            end else begin
                wmax = (gap - 1 < 20) ? gap - 1 : 20;
                rise_after(gap, $urandom_range(1, wmax));
            end
        end

        repeat (3) rise_after(100, 5);
        pulse = 1'b1; tick(5);
        pulse = 1'b0; tick(9);
        chk("middiv_busy", busy_o[0], 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy_o[0], 0);
        chk("abort_rpm", rpm_o[0], 0);
        chk("abort_valid", valid_o[0], 0);
        chk("abort_stalled", stall_o[0], 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        tick(1);
        rise_after(100, 5);
        chk("after_reset_arm_only", rpm_o[0], 0);
        rise_after(100, 5);
        chk("after_reset_rpm", rpm_o[0], 600);
        tick(10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/tach_rpm_meter.md
Name: tach_rpm_meter

Overview:
- Downstream consumer of the tachometer pulse train, whether from the square-wave test generator or the real sensor input.
- Synchronises the pulse, detects rising edges and measures the period in clk cycles between accepted edges.
- Converts that period to RPM with a sequential restoring divider and publishes a saturated 16-bit RPM value with a one-cycle valid strobe.
- Flags a stalled shaft when no edge arrives within a timeout.

Parameters:
- CLK_RATE, 50000000, clk frequency in Hz.
- PPR, 1, tach pulses per revolution (1..16).
- MIN_PERIOD, 1000, minimum accepted edge spacing in cycles; closer edges are rejected as glitches. Must be >= 40.
- TIMEOUT_CYCLES, 100000000, cycles without an accepted edge before stall. Must be > MIN_PERIOD and < 2^32.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- pulse_in  input  1  raw tach pulse, asynchronous to clk
- rpm  output  16  last computed RPM, saturated
- rpm_valid  output  1  one-cycle strobe when rpm updates
- rpm_sat  output  1  high when the last result was clipped to 0xFFFF
- stalled  output  1  high while in timeout
- busy  output  1  high while the divider runs

Behaviour:
- Reset (async assert, sync release): rpm=0, rpm_valid=0, rpm_sat=0, stalled=1, busy=0.
  - Synchroniser and edge register cleared.
  - cnt=0, armed=0, FSM=IDLE.
- Input path: 2-flop synchroniser, then a registered previous value.
  - edge = sync & ~prev.
  - A pulse_in rise is seen as edge 3 clk later.
- Period counter cnt (32 bit):
  - Increments every cycle.
  - Saturates at TIMEOUT_CYCLES.
- Edge handling:
  - Edge with armed=1 and cnt >= MIN_PERIOD is an accepted strobe: period=cnt, cnt<=1.
  - Edge with armed=1 and cnt < MIN_PERIOD is ignored; cnt continues counting.
  - Edge with armed=0 (first edge after reset or after stall): cnt<=1, armed<=1, no measurement.
- Timeout: cnt reaching TIMEOUT_CYCLES with armed=1 causes:
  - rpm<=0, rpm_sat<=0, one rpm_valid pulse.
  - stalled<=1, armed<=0.
  - While stalled, cnt holds at TIMEOUT_CYCLES and no further rpm_valid pulses occur.
- stalled clears on the first accepted strobe after re-arming, in the same cycle that rpm_valid fires.
- Constant NUM = (60*CLK_RATE)/PPR, integer-truncated at elaboration; must fit in 32 bits.
- FSM IDLE -> DIV -> DONE -> IDLE:
  - IDLE: an accepted strobe loads dividend=NUM and divisor=period, clears the remainder, sets busy=1 and goes to DIV.
  - DIV: 32 restoring iterations, one quotient bit per cycle, MSB first, then DONE.
  - DONE: if quotient > 0xFFFF then rpm=0xFFFF and rpm_sat=1, else rpm=quotient[15:0] and rpm_sat=0. Also rpm_valid=1, busy=0, return to IDLE.
  - Accept-to-rpm_valid latency is exactly 34 cycles.
- Divider is always idle at an accepted strobe, because MIN_PERIOD >= 40 exceeds the divider latency.
- rpm holds its value between strobes. rpm_valid is never high for 2 consecutive cycles.
- Reset mid-division aborts immediately to the reset values above.

Test Plan (CLK_RATE=1000, PPR=1, MIN_PERIOD=40, TIMEOUT_CYCLES=5000, so NUM=60000):
1. Rising edges every 100 cycles -> first edge arms with no valid; each later edge gives rpm_valid 37 cycles after the pulse_in rise, rpm=600, stalled drops on the first result.
2. Period 1000 then period 250 -> rpm=60, then rpm=240, each with exactly one rpm_valid.
3. Edges 100 apart with an extra 1-cycle glitch edge 10 cycles after one of them -> glitch ignored, rpm stays 600 on every strobe.
4. PPR=4 with period 50 -> NUM=15000, rpm=300. Then CLK_RATE=50000000, PPR=1, period 40 -> quotient 75000000, rpm=0xFFFF, rpm_sat=1.
5. Edges stop after a 600-rpm result -> 5000 cycles after the last accepted edge: rpm=0, one rpm_valid, stalled=1. Next edge re-arms only; the following edge 100 cycles later gives rpm=600 and stalled=0.
6. Assert rst_n low 10 cycles into DIV -> busy=0, rpm=0, no rpm_valid, stalled=1. After release, the first edge only arms.
